ram_seq: RTL

Sequential record-and-replay memory. It is the write-side counterpart of the sequential ROM reader. A producer streams words in through a put/full handshake until the block is sealed. The same words then come back out in write order through a get/out/empty port whose timing matches the ROM reader. It is used as a capture buffer for test streams, which are replayed later into consumers that expect a ROM-style source.

---
 rtl/ram_seq.sv | 81 ++++++++
 1 files changed

// File: rtl/ram_seq.sv
// Record-and-replay memory: words streamed in during FILL are returned in write
// order during DUMP through a ROM-style get/out/empty port.
module ram_seq #(
   parameter int W    = 8,
   parameter int SIZE = 256,
   localparam int AW  = $clog2(SIZE + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          put,
   input  logic [W-1:0]  in,
   output logic          full,
   input  logic          seal,
   input  logic          clear,
   input  logic          get,
   output logic [W-1:0]  out,
   output logic          empty,
   output logic [AW-1:0] count
);

   localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [AW-1:0] SIZE_C = AW'(SIZE);

   typedef enum logic {FILL, DUMP} state_t;

   state_t        state;
   logic [AW-1:0] wi;
   logic [AW-1:0] ri;
   logic [W-1:0]  m [0:SIZE-1];
   logic          wr_en;

   assign full  = (state == DUMP) | (wi == SIZE_C);
   assign empty = (state == FILL) | (ri == wi);
   assign count = wi;

   // clear and reset both outrank a put landing on the same edge
   assign wr_en = put & ~full & ~clear & ~reset;

   // NOTE: storage is deliberately left out of reset so it maps onto plain RAM;
   // replay can only reach indices below wi, which were all written after clear.
   always_ff @(posedge clock) begin
      if (wr_en)
         m[wi[IW-1:0]] <= in;
   end

   // NOTE: all state here uses non-blocking assignments so every branch sees
   // the pre-edge values of wi/ri/state, matching the hardware it describes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FILL;
         wi    <= '0;
         ri    <= '0;
         out   <= '0;
      end else if (clear) begin
         state <= FILL;
         wi    <= '0;
         ri    <= '0;
      end else begin
         case (state)
            FILL: begin
               if (put && wi != SIZE_C)
                  wi <= wi + 1'b1;
               if (seal) begin
                  state <= DUMP;
                  ri    <= '0;
               end
            end
            DUMP: begin
               if (seal) begin
                  ri <= '0;
               end else if (get && ri != wi) begin
                  out <= m[ri[IW-1:0]];
                  ri  <= ri + 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule
